// File: rtl/avmm_csr_pkg.sv
// Shared types for the Avalon-MM CSR bank.
//   state_e    : bus-side FSM states
//   acc_mode_e : per-register access mode
//   acc_mode() : resolves a register's mode from its RO / W1C mask bits
package avmm_csr_pkg;

  localparam int unsigned ERR_CNT_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    WR_BURST,
    RD_BURST
  } state_e;

  typedef enum logic [1:0] {
    ACC_RW,
    ACC_RO,
    ACC_W1C
  } acc_mode_e;

  // Read-only takes precedence over write-1-to-clear.
  function automatic acc_mode_e acc_mode(input logic ro, input logic w1c);
    if (ro) begin
      return ACC_RO;
    end
    if (w1c) begin
      return ACC_W1C;
    end
    return ACC_RW;
  endfunction

endpackage

// File: rtl/csr_rd_pipe.sv
// Fixed-latency read return pipeline.
//   i_clk / i_arstn : clock, asynchronous active-low reset (flushes all stages)
//   in_valid/in_data: beat issued this cycle
//   out_valid/out_data: beat emerging LATENCY cycles after issue
module csr_rd_pipe #(
  parameter int unsigned DATA_W  = 64,
  parameter int unsigned LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_arstn,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data
);

  logic [LATENCY-1:0]             valid_q, valid_d;
  logic [LATENCY-1:0][DATA_W-1:0] data_q, data_d;

  always_comb begin
    valid_d    = valid_q;
    data_d     = data_q;
    valid_d[0] = in_valid;
    data_d[0]  = in_data;
    for (int unsigned i = 1; i < LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      data_d[i]  = data_q[i-1];
    end
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q[LATENCY-1];
  assign out_data  = data_q[LATENCY-1];

endmodule

// File: rtl/avmm_csr_bank.sv
// Avalon-MM slave CSR bank with bursts, fixed read latency and per-register
// access modes (RW / RO / W1C).
//   i_clk, i_arstn       : clock, asynchronous active-low reset
//   avs_*                : Avalon-MM slave (word addressed, bursting)
//   hw_status_i          : per-register RO value / W1C set bits (flattened)
//   regs_o               : all register contents (flattened, reg i at i*DATA_W)
//   wr_strobe_o          : one-cycle pulse per committed write beat
//   fabric_regsel_i/_o   : combinational fabric readback port
//   err_cnt_o            : saturating count of errored beats / commands
module avmm_csr_bank
  import avmm_csr_pkg::*;
#(
  parameter int unsigned          ADDR_W     = 10,
  parameter int unsigned          DATA_W     = 64,
  parameter int unsigned          NUM_REGS   = 32,
  parameter int unsigned          BURST_W    = 4,
  parameter int unsigned          RD_LATENCY = 2,
  parameter logic [NUM_REGS-1:0]  RO_MASK    = '0,
  parameter logic [NUM_REGS-1:0]  W1C_MASK   = '0
) (
  input  logic                         i_clk,
  input  logic                         i_arstn,
  input  logic [ADDR_W-1:0]            avs_address,
  input  logic                         avs_read,
  input  logic                         avs_write,
  input  logic [DATA_W-1:0]            avs_writedata,
  input  logic [DATA_W/8-1:0]          avs_byteenable,
  input  logic [BURST_W-1:0]           avs_burstcount,
  output logic [DATA_W-1:0]            avs_readdata,
  output logic                         avs_readdatavalid,
  output logic                         avs_waitrequest,
  input  logic [NUM_REGS*DATA_W-1:0]   hw_status_i,
  output logic [NUM_REGS*DATA_W-1:0]   regs_o,
  output logic [NUM_REGS-1:0]          wr_strobe_o,
  input  logic [$clog2(NUM_REGS)-1:0]  fabric_regsel_i,
  output logic [DATA_W-1:0]            fabric_regdata_o,
  output logic [ERR_CNT_W-1:0]         err_cnt_o
);

  localparam int unsigned BE_W  = DATA_W / 8;
  localparam int unsigned SEL_W = $clog2(NUM_REGS);
  // Beat addresses carry one spare bit so a burst running past the top of the
  // address space is seen as out of range instead of wrapping.
  localparam int unsigned BA_W  = ((ADDR_W > BURST_W) ? ADDR_W : BURST_W) + 1;

  state_e                         state_q, state_d;
  logic [BA_W-1:0]                base_q, base_d;
  logic [BURST_W-1:0]             idx_q, idx_d;
  logic [BURST_W-1:0]             rem_q, rem_d;
  logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            strobe_q, strobe_d;
  logic [ERR_CNT_W-1:0]           err_q, err_d;

  logic [BURST_W-1:0]             beat_cnt;
  logic                           wr_en, wr_hit;
  logic [BA_W-1:0]                wr_addr;
  logic                           rd_issue, rd_hit;
  logic [BA_W-1:0]                rd_addr;
  logic [DATA_W-1:0]              rd_data;
  logic                           simul_err;
  logic [1:0]                     err_inc;
  logic [ERR_CNT_W:0]             err_sum;
  logic [DATA_W-1:0]              lane_mask;

  assign beat_cnt = (avs_burstcount == '0) ? BURST_W'(1) : avs_burstcount;

  // Bus FSM: decides which beat (if any) is committed or issued this cycle.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    idx_d     = idx_q;
    rem_d     = rem_q;
    wr_en     = 1'b0;
    wr_addr   = '0;
    rd_issue  = 1'b0;
    rd_addr   = '0;
    simul_err = 1'b0;
    case (state_q)
      IDLE: begin
        if (avs_write) begin
          wr_en     = 1'b1;
          wr_addr   = BA_W'(avs_address);
          simul_err = avs_read;
          base_d    = BA_W'(avs_address);
          idx_d     = BURST_W'(1);
          rem_d     = beat_cnt - BURST_W'(1);
          if (beat_cnt > BURST_W'(1)) begin
            state_d = WR_BURST;
          end
        end else if (avs_read) begin
          rd_issue = 1'b1;
          rd_addr  = BA_W'(avs_address);
          base_d   = BA_W'(avs_address);
          idx_d    = BURST_W'(1);
          rem_d    = beat_cnt - BURST_W'(1);
          if (beat_cnt > BURST_W'(1)) begin
            state_d = RD_BURST;
          end
        end
      end
      WR_BURST: begin
        if (avs_write) begin
          wr_en   = 1'b1;
          wr_addr = base_q + BA_W'(idx_q);
          idx_d   = idx_q + BURST_W'(1);
          rem_d   = rem_q - BURST_W'(1);
          if (rem_q == BURST_W'(1)) begin
            state_d = IDLE;
          end
        end
      end
      RD_BURST: begin
        rd_issue = 1'b1;
        rd_addr  = base_q + BA_W'(idx_q);
        idx_d    = idx_q + BURST_W'(1);
        rem_d    = rem_q - BURST_W'(1);
        if (rem_q == BURST_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign wr_hit  = wr_en && (wr_addr < BA_W'(NUM_REGS));
  assign rd_hit  = rd_issue && (rd_addr < BA_W'(NUM_REGS));
  assign rd_data = rd_hit ? regs_q[rd_addr[SEL_W-1:0]] : '0;

  always_comb begin
    lane_mask = '0;
    for (int unsigned b = 0; b < BE_W; b++) begin
      lane_mask[b*8 +: 8] = {8{avs_byteenable[b]}};
    end
  end

  // Register update: RO tracks hardware, W1C ORs hardware set bits in after the
  // clear so a same-cycle set wins, RW takes the enabled lanes.
  always_comb begin
    regs_d   = regs_q;
    strobe_d = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      logic              sel;
      logic [DATA_W-1:0] hw;
      sel = wr_hit && (wr_addr == BA_W'(i));
      hw  = hw_status_i[i*DATA_W +: DATA_W];
      strobe_d[i] = sel;
      case (acc_mode(RO_MASK[i], W1C_MASK[i]))
        ACC_RO:  regs_d[i] = hw;
        ACC_W1C: regs_d[i] = (regs_q[i] & ~(sel ? (avs_writedata & lane_mask) : '0)) | hw;
        default: begin
          if (sel) begin
            regs_d[i] = (regs_q[i] & ~lane_mask) | (avs_writedata & lane_mask);
          end
        end
      endcase
    end
  end

  always_comb begin
    err_inc = {1'b0, simul_err} + {1'b0, wr_en & ~wr_hit} + {1'b0, rd_issue & ~rd_hit};
    err_sum = {1'b0, err_q} + (ERR_CNT_W+1)'(err_inc);
    err_d   = err_sum[ERR_CNT_W] ? '1 : err_sum[ERR_CNT_W-1:0];
  end

  always_ff @(posedge i_clk or negedge i_arstn) begin
    if (!i_arstn) begin
      state_q  <= IDLE;
      base_q   <= '0;
      idx_q    <= '0;
      rem_q    <= '0;
      regs_q   <= '0;
      strobe_q <= '0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      base_q   <= base_d;
      idx_q    <= idx_d;
      rem_q    <= rem_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
      err_q    <= err_d;
    end
  end

  csr_rd_pipe #(
    .DATA_W  (DATA_W),
    .LATENCY (RD_LATENCY)
  ) u_rd_pipe (
    .i_clk     (i_clk),
    .i_arstn   (i_arstn),
    .in_valid  (rd_issue),
    .in_data   (rd_data),
    .out_valid (avs_readdatavalid),
    .out_data  (avs_readdata)
  );

  assign avs_waitrequest  = !i_arstn || (state_q == RD_BURST);
  assign regs_o           = regs_q;
  assign wr_strobe_o      = strobe_q;
  assign fabric_regdata_o = regs_q[fabric_regsel_i];
  assign err_cnt_o        = err_q;

endmodule

// File: doc/avmm_csr_bank.md
Name: avmm_csr_bank

Overview:
- Parametrised Avalon-MM slave control/status register bank: HPS h2f bridge on one side, FPGA fabric on the other.
- Adds over the single-beat register file:
  - burst reads and writes;
  - fixed, configurable read latency;
  - per-register access modes (RW / RO / W1C);
  - hardware status inputs;
  - per-register write strobes;
  - an error counter.
- Word-addressed; no handshake-delay counters.

Parameters:
- ADDR_W, 10, word address width
- DATA_W, 64, register and bus width (multiple of 8)
- NUM_REGS, 32, number of registers (≤ 2^ADDR_W)
- BURST_W, 4, burstcount width (max burst 2^(BURST_W-1))
- RD_LATENCY, 2, cycles from read-beat issue to readdatavalid (1..4)
- RO_MASK, '0, NUM_REGS bits; bit i=1 → register i read-only
- W1C_MASK, '0, NUM_REGS bits; bit i=1 → register i sticky write-1-to-clear (RO_MASK takes precedence)

Ports:
- i_clk  in  1  clock
- i_arstn  in  1  asynchronous active-low reset
- avs_address  in  ADDR_W  word address of first beat
- avs_read  in  1  read request
- avs_write  in  1  write request
- avs_writedata  in  DATA_W  write data
- avs_byteenable  in  DATA_W/8  byte lanes
- avs_burstcount  in  BURST_W  beats in burst
- avs_readdata  out  DATA_W  read data
- avs_readdatavalid  out  1  read beat valid
- avs_waitrequest  out  1  slave stall
- hw_status_i  in  NUM_REGS*DATA_W  RO value / W1C set bits (flattened, reg i at [i*DATA_W +: DATA_W])
- regs_o  out  NUM_REGS*DATA_W  current register contents to fabric
- wr_strobe_o  out  NUM_REGS  one-cycle pulse per committed beat
- fabric_regsel_i  in  $clog2(NUM_REGS)  fabric readback select
- fabric_regdata_o  out  DATA_W  register selected by fabric_regsel_i (combinational)
- err_cnt_o  out  16  saturating count of errored accesses

Behaviour:
- **Clock/reset:** one clock i_clk; reset asynchronous, active-low (i_arstn).
- **Reset values:**
  - all registers, avs_readdata, avs_readdatavalid, wr_strobe_o and err_cnt_o are 0;
  - FSM is IDLE;
  - read pipeline is flushed.
  - avs_waitrequest=1 while i_arstn=0.
  - Reset mid-burst aborts the burst; no further readdatavalid is produced.
- **FSM states:** IDLE, WR_BURST, RD_BURST.
- **IDLE:** avs_waitrequest=0.
  - avs_write: beat 0 is accepted and committed at this edge; beat counter = burstcount-1; goes to WR_BURST if remaining >0.
  - avs_read: command is accepted; base address and count are latched; beat 0 is issued this cycle; goes to RD_BURST if count >1.
  - burstcount=0 is treated as 1.
- **WR_BURST:** avs_waitrequest=0.
  - Each cycle with avs_write=1 commits one beat at base+n.
  - avs_write=0 inserts an idle beat and does not advance.
  - Last beat returns to IDLE.
- **RD_BURST:** avs_waitrequest=1.
  - Issues one beat per cycle at base+n with no gaps.
  - Returns to IDLE after the last issue. The next command is accepted on the following cycle.
- **Read data path:**
  - Issued beat data (register value at the issue edge) enters csr_rd_pipe.
  - avs_readdatavalid is asserted exactly RD_LATENCY cycles after issue, for one cycle per beat; beats are returned in order.
- **Write commit:**
  - Only lanes with byteenable=1 are updated.
  - RW registers: written lanes take writedata.
  - RO registers: the write is ignored (no error). Register value = hw_status_i slice, registered every cycle.
  - W1C registers: reg <= (reg & ~(writedata & lanes)) | hw_status_i slice. On a same-cycle set and clear, set wins.
  - wr_strobe_o[i] pulses the cycle after a commit to register i, including RO.
- **Out-of-range beats** (address ≥ NUM_REGS; bursts never wrap):
  - writes are dropped;
  - reads return 0 with valid;
  - err_cnt_o increments once per errored beat.
- **Simultaneous avs_read and avs_write in IDLE:** the write is accepted, the read is ignored, and err_cnt_o increments.
- **err_cnt_o** saturates at 16'hFFFF.

Decomposition:
- Package avmm_csr_pkg holds:
  - state enum (IDLE, WR_BURST, RD_BURST);
  - access-mode typedef (ACC_RW, ACC_RO, ACC_W1C);
  - function deriving mode from RO_MASK/W1C_MASK;
  - ERR_CNT_W=16.
- Sub-module csr_rd_pipe: parametrised DATA_W × RD_LATENCY shift pipeline of {valid,data} with async reset.
- Register storage and FSM are implemented inline.

Test Plan:
- **Single RW write/read:** write reg 3 = 64'hDEAD_BEEF_0123_4567, be=8'hFF; read reg 3 with RD_LATENCY=2 → readdatavalid exactly 2 cycles after issue, data matches; wr_strobe_o[3] pulses once.
- **Byteenable:** reg 5 = 64'hFFFF_FFFF_FFFF_FFFF; write 64'h0 with be=8'h0F → reads 64'hFFFF_FFFF_0000_0000.
- **Burst:** 4-beat write at address 8 with avs_write deasserted for 1 cycle mid-burst → regs 8..11 correct. 4-beat read → waitrequest high for 3 cycles after accept, 4 consecutive valid beats in order.
- **W1C:** W1C reg 2 receives hw_status_i=64'h5 pulse → holds 64'h5; write 64'h1 → reads 64'h4; same-cycle set bit 0 and clear bit 0 → bit 0 stays 1.
- **Out-of-range / simultaneous:** NUM_REGS=32 burst read of 3 beats at address 31 → data reg31, 0, 0; err_cnt_o=2. Simultaneous read+write → write committed; err_cnt_o=3.
- **Reset mid-burst:** assert i_arstn=0 during beat 2 of a 4-beat read → all outputs 0 immediately, waitrequest=1; after release, no stray readdatavalid and the FSM accepts a new read.
